fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 redirect_valid  input  1  branch-taken or PC-write redirect request.
REQ-007 redirect_pc  input  WIDTH  redirect target address.
REQ-008 imem_req  output  1  instruction memory read strobe.
REQ-009 imem_addr  output  WIDTH  instruction memory byte address.
REQ-010 imem_rdata  input  WIDTH  read data, valid exactly one cycle after imem_req.
REQ-011 inst_valid  output  1  queue head holds a valid instruction.
REQ-012 inst_ready  input  1  decode accepts the head this cycle.
REQ-013 inst_out  output  WIDTH  head instruction word.
REQ-014 inst_pc  output  WIDTH  address the head instruction was fetched from.
REQ-015 count  output  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-016 Internal state: pc, inflight bit, inflight_pc, DEPTH-entry circular queue of {word, pc} with wrapping read/write pointers.
REQ-017 Issue condition: imem_req = !reset && !redirect_valid && (count + inflight) < DEPTH.
REQ-018 imem_addr = pc at all times; on issue, pc <= pc + 4 (mod 2^WIDTH, wraps silently), inflight <= 1, inflight_pc <= pc.
REQ-019 No issue: inflight <= 0, pc holds.
REQ-020 Inflight set and no redirect this cycle: {imem_rdata, inflight_pc} written at the write pointer at the clock edge; the pointer advances with wrap at DEPTH.
REQ-021 Pop: inst_valid && inst_ready; the read pointer advances with wrap.
REQ-022 Simultaneous push and pop: count unchanged; pop on a full queue, and push on the entry popped that cycle, are both legal.
REQ-023 The credit rule of REQ-017 makes overflow impossible; a push while count==DEPTH and no pop is a design error.
REQ-024 inst_valid = (count != 0); when count==0, inst_out and inst_pc are 0.
REQ-025 Redirect cycle: imem_req=0; at the next edge the queue is emptied (pointers and count to 0), the inflight response is discarded, and pc <= redirect_pc.
REQ-026 A handshake coinciding with redirect counts as completed; the flush still empties the queue.
REQ-027 Redirect latency: redirect at cycle t, request to redirect_pc at t+1, inst_valid=1 with inst_pc=redirect_pc at t+3.
REQ-028 Throughput with inst_ready held at 1 and no redirects: one instruction per cycle after the first.
REQ-029 redirect_pc is used as given; low two bits are not masked.

Reset
REQ-030 reset has priority over every other input, including a simultaneous redirect.
REQ-031 After reset: pc=RESET_PC, inflight=0, pointers and count=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-032 imem_req=0 during the reset cycle; the first request, to RESET_PC, issues in the first cycle after reset deasserts.
REQ-033 Reset mid-operation discards queued and inflight data; no stale push occurs after reset.

Configuration
REQ-034 Macro FETCH_QUEUE_PERF_EN; when defined, adds outputs perf_fetch_cnt and perf_flush_cnt, each 32 bits.
REQ-035 With FETCH_QUEUE_PERF_EN: perf_fetch_cnt increments on each pop; perf_flush_cnt increments on each redirect that discards at least one queued or inflight entry.
REQ-036 With FETCH_QUEUE_PERF_EN: both counters wrap at 2^32 and clear on reset.
REQ-037 Without FETCH_QUEUE_PERF_EN: the counter ports and logic do not exist; all other behaviour is identical.

Verification
REQ-038 Reset, then inst_ready=1 with a memory returning word = address -> imem_addr 0,4,8,... on consecutive cycles; inst_out/inst_pc 0,4,8 from the third cycle after reset, one per cycle.
REQ-039 DEPTH=4, inst_ready=0 -> exactly 4 requests issued; count=4; imem_req=0 thereafter; raising inst_ready drains 0,4,8,12 in order.
REQ-040 Queue holding 3 entries plus one inflight, redirect_pc=0x100 -> next cycle count=0 and imem_addr=0x100; first popped inst_pc=0x100 three cycles after redirect; no old addresses appear.
REQ-041 reset asserted in the same cycle as redirect_valid with redirect_pc=0x200 -> pc=RESET_PC, queue empty, first request to RESET_PC.
REQ-042 pc=32'hFFFF_FFFC, one fetch -> next imem_addr=0; the entry tagged 0xFFFF_FFFC is delivered intact.
REQ-043 FETCH_QUEUE_PERF_EN defined, 5 pops and 2 flushing redirects -> perf_fetch_cnt=5, perf_flush_cnt=2; reset clears both to 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a small circular queue.
//
// Issues one sequential instruction-memory read per cycle while queue
// credit allows, captures each response one cycle later into a DEPTH-entry
// queue tagged with its fetch address, and presents the queue head to decode.
// A redirect flushes the queue, drops the outstanding response and restarts
// fetching at the redirect target.
//
// Optional feature macro: FETCH_QUEUE_PERF_EN
//   When defined, adds perf_fetch_cnt (pops) and perf_flush_cnt (redirects
//   that threw away at least one queued or inflight entry), both 32 bits.
//
// Handshake: an instruction transfers on a cycle where inst_valid and
// inst_ready are both high; inst_valid depends only on registered state and
// never on inst_ready. imem_req has no ready: memory always answers on
// imem_rdata exactly one cycle after a request.
module fetch_queue #(
    parameter int                 WIDTH    = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [WIDTH-1:0]             redirect_pc,
    output logic                         imem_req,
    output logic [WIDTH-1:0]             imem_addr,
    input  logic [WIDTH-1:0]             imem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [WIDTH-1:0]             inst_out,
    output logic [WIDTH-1:0]             inst_pc,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]                  perf_fetch_cnt,
    output logic [31:0]                  perf_flush_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    // Pointer width indexes DEPTH entries; DEPTH is a power of two so the
    // pointers wrap naturally on overflow. Count needs one more value (full).
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Architectural state
    logic [WIDTH-1:0] r_pc;
    logic             r_inflight;
    logic [WIDTH-1:0] r_inflight_pc;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Queue storage: instruction word and the address it came from
    logic [WIDTH-1:0] r_q_word [DEPTH];
    logic [WIDTH-1:0] r_q_pc   [DEPTH];

    // Derived control
    logic [CW:0]      w_occupancy;
    logic             w_credit_ok;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_discard;

    // Credit: entries already queued plus the one response still in flight
    // must leave room for the response of a new request.
    always_comb begin
        w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
        w_credit_ok = (w_occupancy < (CW+1)'(DEPTH));
    end

    // Issue, push and pop decisions for this cycle
    always_comb begin
        w_empty   = (r_count == '0);
        w_issue   = !reset && !redirect_valid && w_credit_ok;
        // A response arriving during a redirect or reset belongs to the old
        // instruction stream and is dropped.
        w_push    = r_inflight && !redirect_valid && !reset;
        w_pop     = !w_empty && inst_ready;
        // A redirect discards work if something stays queued after this
        // cycle's pop, or if a response is still outstanding.
        w_discard = r_inflight || (r_count > {{(CW-1){1'b0}}, w_pop});
    end

    // Output view of the PC and queue head; head reads as zero when empty.
    always_comb begin
        imem_req   = w_issue;
        imem_addr  = r_pc;
        inst_valid = !w_empty;
        inst_out   = w_empty ? '0 : r_q_word[r_rd_ptr];
        inst_pc    = w_empty ? '0 : r_q_pc[r_rd_ptr];
        count      = r_count;
    end

    // PC and inflight tracking: advance on issue, jump on redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc;
            r_inflight    <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + WIDTH'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_word[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Performance counters: delivered instructions and wasteful flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid && w_discard) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    // Flush-waste detection only feeds the performance counters.
    logic w_unused;
    assign w_unused = w_discard;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// A behavioural model keeps the expected instruction queue as a SystemVerilog
// queue of {word, pc} entries plus the outstanding request, and every cycle
// the DUT outputs are compared against it.
module tb_fetch_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [W-1:0] RESET_PC = 32'h0000_0000;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic [W-1:0]  imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [W-1:0]  inst_out;
  logic [W-1:0]  inst_pc;
  logic [CW-1:0] count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_flush_cnt;
`endif

  fetch_queue #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .count          (count)
  );

  // scoreboard / reference model state
  logic [2*W-1:0] exp_q[$];      // {word, pc}, head at index 0
  logic           m_known = 1'b0;
  logic           m_pend  = 1'b0;
  logic [W-1:0]   m_pend_addr = '0;
  logic [W-1:0]   m_pc = RESET_PC;
  logic [31:0]    m_fetch = '0;
  logic [31:0]    m_flush = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory contents: distinct from the address so word/pc mixups show up.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: one clock cycle. Applies inputs, answers the previous request,
  // compares outputs to the model, then advances the model across the edge.
  task automatic cycle(input logic rst, input logic redir, input logic [W-1:0] rpc,
                       input logic rdy);
    logic     exp_req;
    logic     pop;
    int       sz;
    logic [2*W-1:0] head;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    imem_rdata     = m_pend ? mem_word(m_pend_addr) : W'($urandom());
    #1;
    sz      = exp_q.size();
    exp_req = !rst && !redir && ((sz + (m_pend ? 1 : 0)) < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (m_known) begin
      head = (sz != 0) ? exp_q[0] : '0;
      check("imem_addr",  64'(imem_addr),  64'(m_pc));
      check("count",      64'(count),      64'(sz));
      check("inst_valid", 64'(inst_valid), 64'(sz != 0));
      check("inst_out",   64'(inst_out),   64'(head[2*W-1:W]));
      check("inst_pc",    64'(inst_pc),    64'(head[W-1:0]));
`ifdef FETCH_QUEUE_PERF_EN
      check("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
      check("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
`endif
    end
    pop = m_known && (sz != 0) && rdy;
    if (rst) begin
      exp_q.delete();
      m_pend  = 1'b0;
      m_pc    = RESET_PC;
      m_fetch = '0;
      m_flush = '0;
      m_known = 1'b1;
    end else if (redir) begin
      if (pop) m_fetch++;
      if (m_pend || (sz - (pop ? 1 : 0)) > 0) m_flush++;
      exp_q.delete();
      m_pend = 1'b0;
      m_pc   = rpc;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        m_fetch++;
      end
      if (m_pend) exp_q.push_back({mem_word(m_pend_addr), m_pend_addr});
      if (exp_q.size() > DEPTH) check("overflow", 64'(exp_q.size()), 64'(DEPTH));
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; imem_rdata = '0;

    // Reset state, then streaming with decode always ready
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_out", 64'(inst_out), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
    idle(2, 1'b1);
    check("stream_first_valid", 64'(inst_valid), 64'd1);
    check("stream_first_pc", 64'(inst_pc), 64'(RESET_PC));
    idle(10, 1'b1);

    // Decode stalled: queue fills to DEPTH and fetch stops
    do_reset();
    idle(8, 1'b0);
    check("stall_count", 64'(count), 64'(DEPTH));
    check("stall_req", 64'(imem_req), 64'd0);
    idle(5, 1'b1);

    // Redirect with three queued entries and one inflight
    do_reset();
    idle(4, 1'b0);
    check("pre_redir_count", 64'(count), 64'd3);
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    check("redir_count", 64'(count), 64'd0);
    check("redir_addr", 64'(imem_addr), 64'h100);
    idle(2, 1'b0);
    check("redir_lat_valid", 64'(inst_valid), 64'd1);
    check("redir_lat_pc", 64'(inst_pc), 64'h100);
    idle(4, 1'b1);

    // Reset wins over a simultaneous redirect
    idle(3, 1'b0);
    cycle(1'b1, 1'b1, 32'h200, 1'b0);
    check("rst_redir_addr", 64'(imem_addr), 64'(RESET_PC));
    check("rst_redir_count", 64'(count), 64'd0);
    idle(4, 1'b1);

    // Address wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("wrap_addr1", 64'(imem_addr), 64'h0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("wrap_head_pc", 64'(inst_pc), 64'hFFFF_FFFC);
    idle(4, 1'b1);

    // Unaligned redirect target is used as given
    cycle(1'b0, 1'b1, 32'h0000_0123, 1'b1);
    idle(6, 1'b1);

`ifdef FETCH_QUEUE_PERF_EN
    // Counter scenario: 5 pops and 2 flushing redirects from reset
    do_reset();
    idle(2, 1'b0);
    idle(5, 1'b1);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    idle(1, 1'b0);
    cycle(1'b0, 1'b1, 32'h80, 1'b0);
    check("perf_fetch5", 64'(perf_fetch_cnt), 64'd5);
    check("perf_flush2", 64'(perf_flush_cnt), 64'd2);
    do_reset();
    check("perf_fetch_rst", 64'(perf_fetch_cnt), 64'd0);
    check("perf_flush_rst", 64'(perf_flush_cnt), 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic          r_rst;
      logic          r_redir;
      logic          r_rdy;
      logic [W-1:0]  r_pc;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_rdy   = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       r_pc = W'($urandom());
        1:       r_pc = 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
        default: r_pc = W'($urandom_range(0, 16'hFFFF)) & ~32'h3;
      endcase
      cycle(r_rst, r_redir, r_pc, r_rdy);
    end
    idle(8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
